sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, the number of bits per frame.
REQ-002 The block SHALL have parameter CNT_W, default 7, the bit-counter width, equal to clog2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port serial_in, input, 1 bit: serial scan data, MSB first, one bit per clk.
REQ-006 The block SHALL have port frame_start, input, 1 bit: a pulse marking the cycle in which serial_in carries bit WIDTH-1 of a frame.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts data_out.
REQ-008 The block SHALL have port clear_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-009 The block SHALL have port data_out, output, WIDTH bits: the reassembled parallel word.
REQ-010 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is being received (state SHIFT).
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag; a completed frame was dropped.
REQ-013 The block SHALL have port frame_err, output, 1 bit: sticky flag; a frame was aborted by an early frame_start.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of words loaded into data_out.

Function
REQ-015 The FSM SHALL have two states, IDLE and SHIFT, with a WIDTH-bit shift register and a CNT_W-bit bit counter.
REQ-016 IDLE: on frame_start=1, the block SHALL capture serial_in as bit WIDTH-1, set the counter to 1 and enter SHIFT; otherwise it SHALL ignore serial_in.
REQ-017 SHIFT: each cycle, the block SHALL shift serial_in into the LSB (shift left) and increment the counter.
REQ-018 When the counter equals WIDTH-1 in SHIFT, the block SHALL capture the final bit, form the word {shift[WIDTH-2:0], serial_in} and return to IDLE.
REQ-019 Latency: data_valid SHALL be high in the cycle immediately after the final bit is sampled, WIDTH cycles after the frame_start cycle.
REQ-020 A handshake transfer SHALL occur on any edge where data_valid=1 and out_ready=1; data_valid SHALL then clear unless a new word loads on the same edge.
REQ-021 data_out SHALL hold stable while data_valid=1 and no transfer occurs.
REQ-022 On word completion with data_valid=0, or with a transfer on that same edge, data_out SHALL load the new word, data_valid SHALL be 1, and frame_cnt SHALL increment.
REQ-023 On word completion with data_valid=1 and out_ready=0, the new word SHALL be discarded, data_out and frame_cnt SHALL be unchanged, and overrun SHALL be set.
REQ-024 On frame_start=1 in SHIFT, the partial frame SHALL be discarded, frame_err SHALL be set, and the current bit SHALL be taken as bit WIDTH-1 of a new frame (counter=1, stay in SHIFT).
REQ-025 frame_start coinciding with the final bit SHALL count as an early restart per REQ-024; no word SHALL be emitted.
REQ-026 frame_cnt SHALL wrap from 16'hFFFF to 0.
REQ-027 clear_err=1 SHALL clear overrun and frame_err on the next edge; a simultaneous set event SHALL take priority (flag remains 1).
REQ-028 busy SHALL equal 1 exactly while the state is SHIFT.
REQ-029 A frame_start following the final bit on the very next cycle SHALL start a new frame with no dead cycle.

Reset
REQ-030 While reset_n=0, the block SHALL hold state=IDLE and zero the counter and shift register; data_out, data_valid, busy, overrun, frame_err and frame_cnt SHALL all be 0.
REQ-031 Reset assertion mid-frame SHALL discard the partial frame; after release, the block SHALL wait in IDLE for frame_start.

Verification
REQ-032 The bench SHALL cover: frame_start plus 128 bits of 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE, out_ready=1 -> data_valid high one cycle after the last bit, data_out equal to the pattern, frame_cnt=1.
REQ-033 The bench SHALL cover: two back-to-back frames (A, then B, no gap) with out_ready=0 -> data_out=A, overrun=1, frame_cnt=1; then out_ready=1 -> data_valid clears.
REQ-034 The bench SHALL cover: a transfer on the same edge as completion of frame B -> data_out=B, data_valid stays 1, overrun=0, frame_cnt=2.
REQ-035 The bench SHALL cover: frame_start at bit 60 of a frame, then a full frame C -> frame_err=1, data_out=C, exactly one word emitted.
REQ-036 The bench SHALL cover: reset_n pulsed low at bit 64 -> all outputs 0; a following full frame decodes correctly.
REQ-037 The bench SHALL cover: frame_cnt preset by 65535 frames, then one more frame -> frame_cnt=0; and clear_err=1 together with an overrun event -> overrun remains 1.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in / parallel-out frame deserializer. A frame is WIDTH bits sent MSB
// first, with frame_start marking the MSB cycle. Completed words are offered
// on data_out under a valid/ready handshake. Frames that complete while the
// output is still occupied are dropped and flagged (overrun). Frames cut short
// by a new frame_start are flagged as well (frame_err). Both flags are sticky
// until clear_err.

module sipo_deserializer #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  // Per-cycle event decode
  logic             start_frame;  // frame_start seen while idle
  logic             restart;      // frame_start seen mid-frame
  logic             word_done;    // final bit sampled this cycle
  logic             xfer;         // handshake completes on this edge
  logic             load_word;    // completed word goes to data_out
  logic             drop_word;    // completed word is discarded
  logic [WIDTH-1:0] word_nxt;     // word assembled with the final bit

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; frame_start always (re)starts a frame, so a restart on
  // the final-bit cycle stays in SHIFT instead of completing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          state_nxt = SHIFT;
        end else if (bit_cnt == LAST_BIT) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    busy        = (state == SHIFT);
    start_frame = (state == IDLE)  && frame_start;
    restart     = (state == SHIFT) && frame_start;
    word_done   = (state == SHIFT) && !frame_start && (bit_cnt == LAST_BIT);
    xfer        = data_valid && out_ready;
    load_word   = word_done && (!data_valid || xfer);
    drop_word   = word_done && data_valid && !out_ready;
    word_nxt    = {shift_reg[WIDTH-2:0], serial_in};
  end

  // Bit counter: 1 after the MSB, cleared when the frame completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (start_frame || restart) begin
      bit_cnt <= CNT_W'(1);
    end else if (word_done) begin
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Shift register: MSB lands in bit 0 and moves up one place per bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
    end else if (start_frame || restart) begin
      shift_reg <= {{(WIDTH-1){1'b0}}, serial_in};
    end else if (state == SHIFT) begin
      shift_reg <= word_nxt;
    end
  end

  // Output word register: only written when a completed word is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (load_word) begin
      data_out <= word_nxt;
    end
  end

  // Valid flag: a same-edge load wins over the transfer that empties it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_valid <= 1'b0;
    end else if (load_word) begin
      data_valid <= 1'b1;
    end else if (xfer) begin
      data_valid <= 1'b0;
    end
  end

  // Loaded-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (load_word) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Sticky overrun flag; a set event outranks clear_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop_word) begin
      overrun <= 1'b1;
    end else if (clear_err) begin
      overrun <= 1'b0;
    end
  end

  // Sticky framing-error flag; a set event outranks clear_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else if (restart) begin
      frame_err <= 1'b1;
    end else if (clear_err) begin
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer: a 128-bit instance for
// the framing and handshake cases, and a 2-bit instance that runs frames
// fast enough to take frame_cnt through its wrap.

module tb_sipo_deserializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         serial_in;
  logic         frame_start;
  logic         out_ready;
  logic         clear_err;
  logic [127:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic [15:0]  frame_cnt;

  logic         s_serial_in;
  logic         s_frame_start;
  logic         s_out_ready;
  logic         s_clear_err;
  logic [1:0]   s_data_out;
  logic         s_data_valid;
  logic         s_busy;
  logic         s_overrun;
  logic         s_frame_err;
  logic [15:0]  s_frame_cnt;

  int unsigned  checks = 0;
  int unsigned  errors = 0;

  localparam logic [127:0] PAT = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] WA  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] WB  = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_8001;
  localparam logic [127:0] WC  = 128'h8000_0000_FFFF_0000_1111_2222_3333_4445;
  localparam logic [127:0] WX  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  sipo_deserializer #(.WIDTH(128), .CNT_W(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .out_ready   (out_ready),
    .clear_err   (clear_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt)
  );

  sipo_deserializer #(.WIDTH(2), .CNT_W(1)) dut_small (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_in   (s_serial_in),
    .frame_start (s_frame_start),
    .out_ready   (s_out_ready),
    .clear_err   (s_clear_err),
    .data_out    (s_data_out),
    .data_valid  (s_data_valid),
    .busy        (s_busy),
    .overrun     (s_overrun),
    .frame_err   (s_frame_err),
    .frame_cnt   (s_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive bits lo..hi-1 of word w (MSB = bit index 0), frame_start on index 0
  task automatic send_bits(input logic [127:0] w, input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i < hi; i++) begin
      frame_start = (i == 0);
      serial_in   = w[127 - i];
      tick();
    end
    frame_start = 1'b0;
    serial_in   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    frame_start   = 1'b0;
    serial_in     = 1'b0;
    out_ready     = 1'b0;
    clear_err     = 1'b0;
    s_frame_start = 1'b0;
    s_serial_in   = 1'b0;
    s_out_ready   = 1'b0;
    s_clear_err   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_data_out",   data_out,   '0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy",       busy,       0);
    check("rst_overrun",    overrun,    0);
    check("rst_frame_err",  frame_err,  0);
    check("rst_frame_cnt",  frame_cnt,  0);

    // Single frame, ready downstream, latency of the valid flag
    out_ready = 1'b1;
    send_bits(PAT, 0, 127);
    check("pat_busy_mid",   busy,       1);
    check("pat_valid_early",data_valid, 0);
    send_bits(PAT, 127, 128);
    check("pat_valid",      data_valid, 1);
    check("pat_data",       data_out,   PAT);
    check("pat_cnt",        frame_cnt,  1);
    check("pat_busy_end",   busy,       0);
    tick();
    check("pat_xfer_clear", data_valid, 0);

    // Back-to-back frames with downstream stalled: second one is dropped
    do_reset();
    out_ready = 1'b0;
    send_bits(WA, 0, 128);
    send_bits(WB, 0, 128);
    check("ovr_data",       data_out,   WA);
    check("ovr_flag",       overrun,    1);
    check("ovr_cnt",        frame_cnt,  1);
    check("ovr_valid",      data_valid, 1);
    out_ready = 1'b1;
    tick();
    check("ovr_drain",      data_valid, 0);
    check("ovr_sticky",     overrun,    1);

    // Transfer on the same edge that frame B completes
    do_reset();
    out_ready = 1'b0;
    send_bits(WA, 0, 128);
    send_bits(WB, 0, 127);
    out_ready = 1'b1;
    send_bits(WB, 127, 128);
    check("same_data",      data_out,   WB);
    check("same_valid",     data_valid, 1);
    check("same_overrun",   overrun,    0);
    check("same_cnt",       frame_cnt,  2);

    // Early restart at bit 60, then a full frame C
    do_reset();
    out_ready = 1'b1;
    send_bits(WX, 0, 60);
    send_bits(WC, 0, 128);
    check("early_err",      frame_err,  1);
    check("early_data",     data_out,   WC);
    check("early_cnt",      frame_cnt,  1);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("early_clear",    frame_err,  0);

    // Restart coinciding with the final bit: no word from the aborted frame
    send_bits(WX, 0, 127);
    send_bits(WC, 0, 1);
    check("final_rs_err",   frame_err,  1);
    check("final_rs_cnt",   frame_cnt,  1);
    check("final_rs_valid", data_valid, 0);
    send_bits(WC, 1, 128);
    check("final_rs_data",  data_out,   WC);
    check("final_rs_cnt2",  frame_cnt,  2);

    // Asynchronous reset mid-frame with a word pending
    do_reset();
    out_ready = 1'b0;
    send_bits(WA, 0, 128);
    send_bits(WB, 0, 64);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data",   data_out,   '0);
    check("mid_rst_valid",  data_valid, 0);
    check("mid_rst_busy",   busy,       0);
    check("mid_rst_cnt",    frame_cnt,  0);
    check("mid_rst_ovr",    overrun,    0);
    check("mid_rst_ferr",   frame_err,  0);
    tick();
    reset_n   = 1'b1;
    serial_in = 1'b1;
    tick();
    tick();
    serial_in = 1'b0;
    check("mid_rst_idle",   busy,       0);
    out_ready = 1'b1;
    send_bits(WC, 0, 128);
    check("mid_rst_data2",  data_out,   WC);
    check("mid_rst_cnt2",   frame_cnt,  1);

    // clear_err alongside an overrun event: the set wins
    do_reset();
    out_ready = 1'b0;
    send_bits(WA, 0, 128);
    send_bits(WB, 0, 127);
    clear_err = 1'b1;
    send_bits(WB, 127, 128);
    check("clr_vs_set",     overrun,    1);
    tick();
    clear_err = 1'b0;
    check("clr_alone",      overrun,    0);

    // frame_cnt wrap on the narrow instance
    do_reset();
    s_out_ready = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      s_frame_start = 1'b1;
      s_serial_in   = n[0];
      tick();
      s_frame_start = 1'b0;
      s_serial_in   = ~n[0];
      tick();
    end
    check("wrap_preset",    s_frame_cnt, 16'hFFFF);
    s_frame_start = 1'b1;
    s_serial_in   = 1'b1;
    tick();
    s_frame_start = 1'b0;
    s_serial_in   = 1'b0;
    tick();
    check("wrap_cnt",       s_frame_cnt, 0);
    check("wrap_data",      s_data_out,  2'b10);
    check("wrap_valid",     s_data_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
